// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared fetch-control definitions: FSM state encoding, instruction size,
// default reset vector and the redirect-target alignment helper.
package pc_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FULL  = 2'd3
   } fetch_state_e;

   localparam int          INSTR_BYTES      = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Drops the byte offset so fetches always land on a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Program counter owner and instruction-memory fetch port, with a one-entry
// output buffer handing instructions to decode over valid/ready.
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [ADDR_W-1:0] imem_rdata,
   output logic              inst_valid,
   input  logic              decode_ready,
   output logic [ADDR_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [ADDR_W-1:0] pc_plus4,
   output logic              misalign
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
   logic              inst_valid_q, inst_valid_d;
   logic              misalign_q, misalign_d;
   logic [ADDR_W-1:0] target;

   assign target = {redirect_pc[ADDR_W-1:2], 2'b00};

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      addr_d       = addr_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;
      misalign_d   = redirect_valid && (redirect_pc[1:0] != 2'b00);

      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
            if (redirect_valid) begin
               pc_d   = target;
               addr_d = target;
            end
         end
         ST_FETCH: begin
            if (imem_ack) begin
               if (redirect_valid) begin
                  pc_d   = target;
                  addr_d = target;
               end else begin
                  inst_d       = imem_rdata;
                  inst_pc_d    = addr_q;
                  inst_valid_d = 1'b1;
                  pc_d         = pc_q + STEP;
                  state_d      = ST_FULL;
               end
            end else if (redirect_valid) begin
               // Address must stay put until memory answers the old request.
               pc_d    = target;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (redirect_valid) pc_d = target;
            if (imem_ack) begin
               addr_d  = redirect_valid ? target : pc_q;
               state_d = ST_FETCH;
            end
         end
         ST_FULL: begin
            if (redirect_valid) begin
               inst_valid_d = 1'b0;
               pc_d         = target;
               addr_d       = target;
               state_d      = ST_FETCH;
            end else if (decode_ready) begin
               inst_valid_d = 1'b0;
               addr_d       = pc_q;
               state_d      = ST_FETCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         addr_q       <= RESET_PC;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         inst_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         addr_q       <= addr_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
         misalign_q   <= misalign_d;
      end
   end

   assign imem_req   = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
   assign imem_addr  = addr_q;
   assign inst_valid = inst_valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign pc_plus4   = inst_pc_q + STEP;
   assign misalign   = misalign_q;

endmodule
